// File: rtl/sobel_cpu_0_debug_mon_ctrl.sv
// sobel_cpu_0_debug_mon_ctrl
// Debug-monitor access engine sitting behind the cpu_0 JTAG debug module's
// sysclk stage. Decodes take_*_ocimem_* strobes plus the jdo word into
// single-word read/write transfers on the debug-memory master port, and
// reports MonDReg / monitor_ready / monitor_error back for host polling.
//
// Optional feature macro: DEBUG_MON_ADDR_AUTOINC_EN
//   defined   -> mon_address advances by one after every accepted transfer
//   undefined -> mon_address changes only on an ocimem_a address load
module sobel_cpu_0_debug_mon_ctrl #(
    parameter int AW             = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    output logic [AW-1:0] mon_address,
    output logic          mon_read,
    output logic          mon_write,
    output logic [31:0]   mon_writedata,
    input  logic [31:0]   mon_readdata,
    input  logic          mon_waitrequest
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // The counter holds the number of stalled cycles already seen in this
    // transfer; the stall that would bring it to TIMEOUT_CYCLES aborts.
    localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          any_strobe;
    logic          accept;
    logic          unused_jdo;

    assign any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept        = (mon_read | mon_write) & ~mon_waitrequest;
    assign mon_writedata = MonDReg;
    // Only slices of jdo are decoded; fold the rest so nothing dangles.
    assign unused_jdo    = ^jdo;

    // Command decode, transfer FSM, timeout and status flags in one registered block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            mon_address   <= '0;
            mon_read      <= 1'b0;
            mon_write     <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (take_action_ocimem_a) begin
                        mon_address   <= jdo[AW+16:17];
                        monitor_error <= 1'b0;
                        if (jdo[35]) begin
                            state         <= RD;
                            mon_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                        end else begin
                            // Address-only load completes immediately.
                            monitor_ready <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        state         <= WR;
                        mon_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        state         <= RD;
                        mon_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                    end
                end

                RD, WR: begin
                    // Any strobe while busy (including the accept cycle) is lost.
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (accept) begin
                        if (state == RD) begin
                            MonDReg <= mon_readdata;
                        end
`ifdef DEBUG_MON_ADDR_AUTOINC_EN
                        mon_address <= mon_address + AW'(1);
`endif
                        monitor_ready <= 1'b1;
                        mon_read      <= 1'b0;
                        mon_write     <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= IDLE;
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        // Abort: MonDReg and address are left as they were.
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        mon_read      <= 1'b0;
                        mon_write     <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= IDLE;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    mon_read  <= 1'b0;
                    mon_write <= 1'b0;
                    tmo_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_cpu_0_debug_mon_ctrl.sv
// Scoreboard bench for sobel_cpu_0_debug_mon_ctrl. The driver computes the
// expected bus transfer and status update for every command from the
// command semantics and queues them; a monitor process pops and compares
// whenever a bus request ends or monitor_ready rises.
module tb_sobel_cpu_0_debug_mon_ctrl;

    localparam int AW  = 10;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          ta, tb_b, tna;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;
    logic [AW-1:0] mon_address;
    logic          mon_read, mon_write;
    logic [31:0]   mon_writedata;
    logic [31:0]   mon_readdata;
    logic          mon_waitrequest;

    sobel_cpu_0_debug_mon_ctrl #(.AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (ta),
        .take_action_ocimem_b   (tb_b),
        .take_no_action_ocimem_a(tna),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .mon_address            (mon_address),
        .mon_read               (mon_read),
        .mon_write              (mon_write),
        .mon_writedata          (mon_writedata),
        .mon_readdata           (mon_readdata),
        .mon_waitrequest        (mon_waitrequest)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            len;
    } bus_t;

    typedef struct {
        logic [31:0]   dreg;
        bit            err;
        logic [AW-1:0] addr;
        int            due;
    } stat_t;

    bus_t  bus_q[$];
    stat_t stat_q[$];

    // Reference state of the monitor as seen by the host.
    logic [31:0]   m_dreg  = '0;
    bit            m_err   = 1'b0;
    bit            m_ready = 1'b0;
    logic [AW-1:0] m_addr  = '0;

    // Slave behaviour for the transfer about to be issued.
    int          cur_stall = 0;
    logic [31:0] cur_rdata = '0;
    int          scnt      = 0;

    initial begin
        mon_waitrequest = 1'b0;
        mon_readdata    = '0;
    end

    // Slave: stall cur_stall cycles of each request, then accept.
    always @(negedge clk) begin
        if (mon_read === 1'b1 || mon_write === 1'b1) begin
            if (scnt < cur_stall) begin
                mon_waitrequest = 1'b1;
                mon_readdata    = $urandom;
                scnt++;
            end else begin
                mon_waitrequest = 1'b0;
                mon_readdata    = cur_rdata;
            end
        end else begin
            scnt            = 0;
            mon_waitrequest = 1'($urandom_range(0, 1));
            mon_readdata    = $urandom;
        end
    end

    // Monitor: compares each finished bus request and each rise of monitor_ready.
    bit            mon_en   = 1'b0;
    bit            req_prev = 1'b0;
    bit            rdy_prev = 1'b0;
    int            rlen     = 0;
    bit            r_wr;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;

    always @(negedge clk) begin
        bus_t  eb;
        stat_t es;
        bit    req;
        #1;
        req = (mon_read === 1'b1) || (mon_write === 1'b1);
        if (mon_en) begin
            if (req) begin
                rlen++;
                r_wr   = (mon_write === 1'b1);
                r_addr = mon_address;
                r_data = mon_writedata;
            end else if (req_prev) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_request", 1, 0);
                end else begin
                    eb = bus_q.pop_front();
                    check("bus_dir", r_wr, eb.wr);
                    check("bus_addr", r_addr, eb.addr);
                    check("bus_len", rlen, eb.len);
                    if (eb.wr) check("bus_wdata", r_data, eb.data);
                end
                rlen = 0;
            end
            if (monitor_ready === 1'b1 && !rdy_prev) begin
                if (stat_q.size() == 0) begin
                    check("status_unexpected_ready", 1, 0);
                end else begin
                    es = stat_q.pop_front();
                    check("status_cycle", cyc, es.due);
                    check("status_MonDReg", MonDReg, es.dreg);
                    check("status_error", monitor_error, es.err);
                    check("status_address", mon_address, es.addr);
                end
            end
        end else begin
            rlen = 0;
        end
        req_prev = req;
        rdy_prev = (monitor_ready === 1'b1);
    end

    task automatic clear_strobes();
        ta   = 1'b0;
        tb_b = 1'b0;
        tna  = 1'b0;
    endtask

    task automatic rand_jdo();
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        jdo = r64[37:0];
    endtask

    // kind 0: ocimem_a (rd selects jdo[35]); 1: ocimem_b; 2: no_action read.
    task automatic do_cmd(input int kind, input bit rd, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input int stall,
                          input logic [31:0] rdata, input bit extra, input bit noise);
        bit   xfer, is_wr, timed;
        int   len, c0, xj;
        stat_t s;
        bus_t  b;
        cur_stall = stall;
        cur_rdata = rdata;
        @(posedge clk); #1;
        rand_jdo();
        case (kind)
            0: begin
                ta = 1'b1;
                jdo[AW+16:17] = addr;
                jdo[35] = rd;
                if (noise) begin
                    tb_b = 1'($urandom);
                    tna  = 1'($urandom);
                end
            end
            1: begin
                tb_b = 1'b1;
                jdo[34:3] = wdata;
                if (noise) tna = 1'($urandom);
            end
            default: tna = 1'b1;
        endcase
        c0 = cyc;

        xfer  = 1'b1;
        is_wr = (kind == 1);
        if (kind == 0) begin
            m_addr = addr;
            xfer   = rd;
        end
        if (kind == 1) m_dreg = wdata;
        timed = (TMO != 0) && (stall >= TMO);
        len   = timed ? TMO : stall + 1;
        xj    = extra ? $urandom_range(1, len) : 0;
        if (!xfer) begin
            m_err = 1'b0;
            if (!m_ready) begin
                s = '{dreg: m_dreg, err: 1'b0, addr: m_addr, due: c0 + 1};
                stat_q.push_back(s);
            end
            m_ready = 1'b1;
        end else begin
            b = '{wr: is_wr, addr: m_addr, data: m_dreg, len: len};
            bus_q.push_back(b);
            m_err = extra;
            if (timed) begin
                m_err = 1'b1;
            end else begin
                if (!is_wr) m_dreg = rdata;
`ifdef DEBUG_MON_ADDR_AUTOINC_EN
                m_addr = m_addr + 1'b1;
`endif
            end
            s = '{dreg: m_dreg, err: m_err, addr: m_addr, due: c0 + 1 + len};
            stat_q.push_back(s);
            m_ready = 1'b1;
        end

        @(posedge clk); #1;
        clear_strobes();
        if (xfer) begin
            for (int j = 1; j <= len; j++) begin
                if (j == xj) begin
                    rand_jdo();
                    case ($urandom_range(0, 2))
                        0:       ta   = 1'b1;
                        1:       tb_b = 1'b1;
                        default: tna  = 1'b1;
                    endcase
                end
                @(posedge clk); #1;
                clear_strobes();
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_MonDReg"}, MonDReg, 0);
        check({tag, "_ready"}, monitor_ready, 0);
        check({tag, "_error"}, monitor_error, 0);
        check({tag, "_address"}, mon_address, 0);
        check({tag, "_read"}, mon_read, 0);
        check({tag, "_write"}, mon_write, 0);
        check({tag, "_writedata"}, mon_writedata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            kind, stall;
        bit            rd, extra;
        logic [AW-1:0] a;

        clear_strobes();
        jdo   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");
        mon_en = 1'b1;

        // Read at address 5, no stall.
        do_cmd(0, 1'b1, AW'(5), 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Write with three stall cycles.
        do_cmd(1, 1'b0, '0, 32'h12345678, 3, 32'h0, 1'b0, 1'b0);
        // Read stuck in waitrequest: timeout abort.
        do_cmd(2, 1'b0, '0, 32'h0, 20, 32'hCAFEF00D, 1'b0, 1'b0);
        // Strobe during a stalled read, then a clean read clears the error.
        do_cmd(2, 1'b0, '0, 32'h0, 3, 32'h0BADF00D, 1'b1, 1'b0);
        do_cmd(2, 1'b0, '0, 32'h0, 0, 32'h00C0FFEE, 1'b0, 1'b0);
        // Top-of-range address followed by two streaming reads.
        do_cmd(0, 1'b0, AW'(10'h3FF), 32'h0, 0, 32'h0, 1'b0, 1'b0);
        do_cmd(2, 1'b0, '0, 32'h0, 0, 32'h11111111, 1'b0, 1'b0);
        do_cmd(2, 1'b0, '0, 32'h0, 1, 32'h22222222, 1'b0, 1'b0);

        // Randomised command mix.
        for (int i = 0; i < 300; i++) begin
            kind  = $urandom_range(0, 2);
            rd    = ($urandom_range(0, 3) != 0);
            a     = ($urandom_range(0, 7) == 0) ? AW'(10'h3FF) : AW'($urandom);
            stall = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(TMO, TMO + 3);
            extra = ($urandom_range(0, 4) == 0);
            do_cmd(kind, rd, a, $urandom, stall, $urandom, extra, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #2;
        check("bus_queue_drained", bus_q.size(), 0);
        check("status_queue_drained", stat_q.size(), 0);

        // Reset in the middle of a stalled read drops the request.
        mon_en    = 1'b0;
        cur_stall = 50;
        @(posedge clk); #1;
        tna = 1'b1;
        @(posedge clk); #1;
        clear_strobes();
        @(posedge clk); #1;
        check("midreset_read_active", mon_read, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
